// File: rtl/bw_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bw_pkg
// Brief    : Shared width, FSM encoding and Baugh-Wooley correction constant.
// Revision : 1.0
// ============================================================================
package bw_pkg;

  localparam int DEFAULT_M = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Correction term 2^m + 2^(2m-1); callers keep the low 2m bits.
  function automatic logic [63:0] bw_correction(input int m);
    return (64'd1 << m) | (64'd1 << (2 * m - 1));
  endfunction

endpackage
`default_nettype wire

// File: rtl/bw_pp_row.sv
`default_nettype none
// ============================================================================
// Module   : bw_pp_row
// Brief    : One Baugh-Wooley partial-product row (AND gating + sign inversions).
// Revision : 1.0
// ============================================================================
module bw_pp_row #(
  parameter int M = 5
) (
  input  logic [M-1:0] a,
  input  logic         b_bit,
  input  logic         last,
  output logic [M-1:0] row
);

  logic [M-1:0] w_and;

  assign w_and = a & {M{b_bit}};

  // The final row inverts the magnitude bits; every other row inverts only the sign bit.
  assign row = last ? {w_and[M-1], ~w_and[M-2:0]}
                    : {~w_and[M-1], w_and[M-2:0]};

endmodule
`default_nettype wire

// File: rtl/bw_seq_multiplier.sv
`default_nettype none
// ============================================================================
// Module   : bw_seq_multiplier
// Brief    : Iterative signed MxM Baugh-Wooley multiplier, one row per clock.
// Revision : 1.0
// ============================================================================
module bw_seq_multiplier
  import bw_pkg::*;
#(
  parameter int M = DEFAULT_M
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [M-1:0]   a,
  input  logic [M-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*M-1:0] p
);

  localparam int              CW          = $clog2(M);
  localparam logic [63:0]     C_CORR_FULL = bw_correction(M);
  localparam logic [2*M-1:0]  C_CORR      = C_CORR_FULL[2*M-1:0];

  state_t           r_state;
  logic [M-1:0]     r_a;
  logic [M-1:0]     r_b;
  logic [CW-1:0]    r_cnt;
  logic [2*M-1:0]   r_acc;
  logic [2*M-1:0]   r_p;
  logic             r_busy;
  logic             r_done;

  logic             w_last;
  logic [M-1:0]     w_row;
  logic [2*M-1:0]   w_addend;
  logic [2*M-1:0]   w_acc_next;

  assign w_last     = (r_cnt == CW'(M - 1));
  assign w_addend   = {{M{1'b0}}, w_row} << r_cnt;
  assign w_acc_next = r_acc + w_addend;

  bw_pp_row #(.M(M)) u_row (
    .a     (r_a),
    .b_bit (r_b[r_cnt]),
    .last  (w_last),
    .row   (w_row)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_p     <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        // DONE is also ready, which is what allows back-to-back operation.
        IDLE, DONE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_cnt   <= '0;
            r_acc   <= C_CORR;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end else begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        RUN: begin
          r_acc <= w_acc_next;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            r_p     <= w_acc_next;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= DONE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign p    = r_p;

endmodule
`default_nettype wire

// File: tb/tb_bw_seq_multiplier.sv
`default_nettype none
// ============================================================================
// Module   : tb_bw_seq_multiplier
// Brief    : Directed and sweep tests for bw_seq_multiplier (M=5 and M=8).
// Revision : 1.0
// ============================================================================
module tb_bw_seq_multiplier;

  logic        clk;
  logic        rst;
  logic        start;
  logic [4:0]  a;
  logic [4:0]  b;
  logic        busy;
  logic        done;
  logic [9:0]  p;

  logic        start8;
  logic [7:0]  a8;
  logic [7:0]  b8;
  logic        busy8;
  logic        done8;
  logic [15:0] p8;

  int tests_run;
  int tests_failed;

  bw_seq_multiplier #(.M(5)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .p     (p)
  );

  bw_seq_multiplier #(.M(8)) dut8 (
    .clk   (clk),
    .rst   (rst),
    .start (start8),
    .a     (a8),
    .b     (b8),
    .busy  (busy8),
    .done  (done8),
    .p     (p8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Start one M=5 operation and wait for done; lat counts edges after acceptance.
  task automatic do_mul(input logic [4:0] va, input logic [4:0] vb,
                        output logic [9:0] rp, output int lat,
                        output int busy_cycles, output logic stable);
    logic [9:0] p_before;
    @(negedge clk);
    a = va; b = vb; start = 1'b1;
    p_before = p;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0; busy_cycles = 0; stable = 1'b1;
    while (!done && lat < 20) begin
      if (busy) busy_cycles++;
      if (p !== p_before) stable = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    rp = p;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    start8 = 1'b0; a8 = '0; b8 = '0;
    #1;
    tests_run++;
    if ({busy, done, p} !== 12'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: busy=%b done=%b p=%h, required 0 0 000", busy, done, p);
    end
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [9:0] rp; int lat; int bc; logic st;
    do_mul(5'd15, 5'd15, rp, lat, bc, st);
    tests_run++;
    if (rp !== 10'h0E1) begin
      tests_failed++; $display("FAIL basic_15x15: p=%h required 0e1", rp);
    end
    tests_run++;
    if (lat !== 5) begin
      tests_failed++; $display("FAIL basic_latency: edges=%0d required 5", lat);
    end
    tests_run++;
    if (bc !== 5 || busy !== 1'b0) begin
      tests_failed++; $display("FAIL basic_busy: busy_cycles=%0d busy_at_done=%b required 5 0", bc, busy);
    end
    @(posedge clk); #1;
    tests_run++;
    if (done !== 1'b0 || p !== 10'h0E1) begin
      tests_failed++; $display("FAIL basic_done_pulse: done=%b p=%h required 0 0e1", done, p);
    end
  endtask

  task automatic test_signed();
    logic [4:0] va [6];
    logic [4:0] vb [6];
    logic [9:0] ve [6];
    logic [9:0] rp; int lat; int bc; logic st;
    va[0] = 5'h10; vb[0] = 5'h10; ve[0] = 10'h100;  // -16 * -16
    va[1] = 5'h10; vb[1] = 5'h0F; ve[1] = 10'h310;  // -16 * 15
    va[2] = 5'h07; vb[2] = 5'h1D; ve[2] = 10'h3EB;  // 7 * -3
    va[3] = 5'h1F; vb[3] = 5'h1F; ve[3] = 10'h001;  // -1 * -1
    va[4] = 5'h00; vb[4] = 5'h10; ve[4] = 10'h000;  // 0 * -16
    va[5] = 5'h17; vb[5] = 5'h00; ve[5] = 10'h000;  // -9 * 0
    for (int k = 0; k < 6; k++) begin
      do_mul(va[k], vb[k], rp, lat, bc, st);
      tests_run++;
      if (rp !== ve[k] || lat !== 5) begin
        tests_failed++;
        $display("FAIL signed_vec%0d: a=%h b=%h p=%h lat=%0d required p=%h lat=5",
                 k, va[k], vb[k], rp, lat, ve[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int n; int first; int second;
    logic [9:0] r1; logic [9:0] r2;
    @(negedge clk);
    a = 5'd3; b = 5'h1E; start = 1'b1;
    @(posedge clk); #1;
    n = 0; first = -1; second = -1; r1 = '0; r2 = '0;
    while (second < 0 && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (done) begin
        if (first < 0) begin
          first = n; r1 = p; a = 5'd5; b = 5'd6;
        end else begin
          second = n; r2 = p; start = 1'b0;
        end
      end else if (first >= 0 && n == first + 2) begin
        a = 5'h1F; b = 5'h1F;
      end
    end
    start = 1'b0;
    tests_run++;
    if (r1 !== 10'h3FA) begin
      tests_failed++; $display("FAIL b2b_first: p=%h required 3fa", r1);
    end
    tests_run++;
    if (r2 !== 10'd30) begin
      tests_failed++; $display("FAIL b2b_second: p=%h required 01e", r2);
    end
    tests_run++;
    if (first !== 5 || second - first !== 6) begin
      tests_failed++; $display("FAIL b2b_spacing: first=%0d second=%0d required 5 11", first, second);
    end
  endtask

  task automatic test_reset_abort();
    int seen; logic [9:0] rp; int lat; int bc; logic st;
    @(negedge clk);
    a = 5'd11; b = 5'h19; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    tests_run++;
    if (busy !== 1'b1 || p !== 10'd30) begin
      tests_failed++; $display("FAIL abort_pre: busy=%b p=%h required 1 01e", busy, p);
    end
    rst = 1'b1; #1;
    tests_run++;
    if ({busy, done, p} !== 12'd0) begin
      tests_failed++; $display("FAIL abort_async: busy=%b done=%b p=%h required 0 0 000", busy, done, p);
    end
    #9 rst = 1'b0;
    seen = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    tests_run++;
    if (seen !== 0 || p !== 10'd0) begin
      tests_failed++; $display("FAIL abort_no_done: done_pulses=%0d p=%h required 0 000", seen, p);
    end
    do_mul(5'd11, 5'h19, rp, lat, bc, st);
    tests_run++;
    if (rp !== 10'h3B3) begin
      tests_failed++; $display("FAIL abort_restart: p=%h required 3b3", rp);
    end
  endtask

  task automatic test_exhaustive_m5();
    logic [9:0] rp; int lat; int bc; logic st;
    logic [4:0] va; logic [4:0] vb;
    logic signed [9:0] exp_p;
    for (int ia = 0; ia < 32; ia++) begin
      for (int ib = 0; ib < 32; ib++) begin
        va = 5'(ia); vb = 5'(ib);
        exp_p = $signed(va) * $signed(vb);
        do_mul(va, vb, rp, lat, bc, st);
        tests_run++;
        if (rp !== exp_p || lat !== 5 || st !== 1'b1) begin
          tests_failed++;
          $display("FAIL sweep_m5: a=%h b=%h p=%h lat=%0d stable=%b required p=%h lat=5 stable=1",
                   va, vb, rp, lat, st, exp_p);
        end
      end
    end
  endtask

  task automatic test_random_m8();
    int lat;
    logic [7:0] va; logic [7:0] vb;
    logic signed [15:0] exp_p;
    for (int k = 0; k < 2000; k++) begin
      va = (k == 0) ? 8'h80 : 8'($urandom);
      vb = (k == 0) ? 8'h80 : 8'($urandom);
      exp_p = $signed(va) * $signed(vb);
      @(negedge clk);
      a8 = va; b8 = vb; start8 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0;
      lat = 0;
      while (!done8 && lat < 30) begin
        @(posedge clk); #1;
        lat++;
      end
      tests_run++;
      if (p8 !== exp_p || lat !== 8) begin
        tests_failed++;
        $display("FAIL random_m8: a=%h b=%h p=%h lat=%0d required p=%h lat=8",
                 va, vb, p8, lat, exp_p);
      end
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    test_reset();
    test_basic();
    test_signed();
    test_back_to_back();
    test_reset_abort();
    test_exhaustive_m5();
    test_random_m8();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
